adder_flit_injector: RTL and testbench

//  Synthesizable traffic source that sits directly upstream of the adder under characterization.

---
 rtl/adder_char_pkg.sv | 14 +
 rtl/thermo_pattern_gen.sv | 43 ++++
 rtl/adder_flit_injector.sv | 119 +++++++++++
 tb/tb_adder_flit_injector.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/adder_char_pkg.sv
// adder_char_pkg: shared injector state type and thermometer-walk word builder
//   thermo_word(p, ph, w): w-bit word; ph=0 -> top p bits ones, ph=1 -> top p bits zero
package adder_char_pkg;
    localparam int INJ_N = 25;
    localparam int MAX_W = 128;
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} inj_state_e;
    function automatic logic [MAX_W-1:0] thermo_word(input int p, input logic ph, input int w = 2 * INJ_N);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++)
            if (i < w) r[i] = (i >= w - p) ^ ph;
        return r;
    endfunction
endpackage

// File: rtl/thermo_pattern_gen.sv
// thermo_pattern_gen: holds the thermometer walk state (p, ph) and exposes the next word
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the walk from p=0, ph=0 (takes effect together with adv)
//   adv      : commit one advance
//   word     : word of the state reached by this cycle's advance (from 0 when clr)
module thermo_pattern_gen
    import adder_char_pkg::*;
#(
    parameter int N    = 25,
    parameter int STEP = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           adv,
    output logic [2*N-1:0] word
);
    localparam int PW = $clog2(2 * N + 1);
    logic [PW-1:0] r_p;
    logic          r_ph;
    logic [PW-1:0] w_base_p;
    logic          w_base_ph;
    logic [31:0]   w_sum;
    logic          w_wrap;
    logic [PW-1:0] w_np;
    logic          w_nph;
    assign w_base_p  = clr ? '0 : r_p;
    assign w_base_ph = clr ? 1'b0 : r_ph;
    assign w_sum     = 32'(w_base_p) + 32'(STEP);
    assign w_wrap    = w_sum > 32'(2 * N);
    assign w_np      = PW'(w_wrap ? w_sum - 32'(2 * N) : w_sum);
    assign w_nph     = w_base_ph ^ w_wrap;
    assign word      = (2 * N)'(thermo_word(int'(w_np), w_nph, 2 * N));
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p  <= '0;
            r_ph <= 1'b0;
        end else if (adv || clr) begin
            r_p  <= adv ? w_np : '0;
            r_ph <= adv ? w_nph : 1'b0;
        end
    end
endmodule

// File: rtl/adder_flit_injector.sv
// adder_flit_injector: packetised thermometer-walk operand source for adder characterization
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle run request, accepted only in IDLE
//   num_pkts   : packets in the run, sampled on accepted start
//   out_valid  : operand pair valid; out_ready accepts it
//   operand_a  : word[N-1:0], operand_b : word[2N-1:N]
//   out_last   : last flit of the packet
//   busy, done : run in progress / one-cycle completion pulse
//   toggle_cnt : accumulated bit toggles, present only with INJ_TOGGLE_COUNT_EN
module adder_flit_injector
    import adder_char_pkg::*;
#(
    parameter int N       = 25,
    parameter int PAYLOAD = 20,
    parameter int GAP     = 7,
    parameter int STEP    = 7,
    parameter int PKT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PKT_W-1:0] num_pkts,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     operand_a,
    output logic [N-1:0]     operand_b,
    output logic             out_last,
    output logic             busy,
    output logic             done
`ifdef INJ_TOGGLE_COUNT_EN
    ,
    output logic [31:0]      toggle_cnt
`endif
);
    localparam int FW = PAYLOAD > 1 ? $clog2(PAYLOAD) : 1;
    localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
    inj_state_e       r_state, w_nstate;
    logic [2*N-1:0]   r_word, w_gen_word;
    logic [FW-1:0]    r_flit;
    logic [GW-1:0]    r_gap;
    logic [PKT_W-1:0] r_rem;
    logic             w_start, w_acc, w_pkt_end, w_gap_end, w_clr, w_adv;
    assign w_start   = start && r_state == IDLE;
    assign w_acc     = r_state == SEND && out_ready;
    assign w_pkt_end = r_flit == FW'(PAYLOAD - 1);
    assign w_gap_end = r_gap == GW'(GAP - 1);
    assign out_valid = r_state == SEND;
    assign out_last  = out_valid && w_pkt_end;
    assign busy      = r_state != IDLE;
    assign done      = r_state == DONE;
    assign operand_a = r_word[N-1:0];
    assign operand_b = r_word[2*N-1:N];
    thermo_pattern_gen #(.N(N), .STEP(STEP)) u_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .adv  (w_adv),
        .word (w_gen_word)
    );
    // Every new packet restarts the walk (clr) and loads its first flit (adv) in one cycle.
    always_comb begin
        w_nstate = r_state;
        w_clr    = 1'b0;
        w_adv    = 1'b0;
        case (r_state)
            IDLE: if (start) begin
                w_nstate = num_pkts == '0 ? DONE : SEND;
                w_clr    = num_pkts != '0;
                w_adv    = num_pkts != '0;
            end
            SEND: if (out_ready) begin
                if (!w_pkt_end) w_adv = 1'b1;
                else if (r_rem == '0) w_nstate = DONE;
                else if (GAP == 0) begin
                    w_clr = 1'b1;
                    w_adv = 1'b1;
                end else w_nstate = adder_char_pkg::GAP;
            end
            adder_char_pkg::GAP: if (w_gap_end) begin
                w_nstate = SEND;
                w_clr    = 1'b1;
                w_adv    = 1'b1;
            end
            DONE: w_nstate = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_flit  <= '0;
            r_gap   <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_nstate;
            if (w_adv) r_word <= w_gen_word;
            r_flit <= w_clr ? '0 : w_adv ? r_flit + 1'b1 : r_flit;
            r_gap  <= r_state == adder_char_pkg::GAP ? r_gap + 1'b1 : '0;
            if (w_start) r_rem <= num_pkts - PKT_W'(1);
            else if (w_acc && w_pkt_end && r_rem != '0) r_rem <= r_rem - PKT_W'(1);
        end
    end
`ifdef INJ_TOGGLE_COUNT_EN
    logic [2*N-1:0] r_prev;
    logic [31:0]    r_tog;
    logic [32:0]    w_tsum;
    assign w_tsum     = {1'b0, r_tog} + 33'($countones(r_word ^ r_prev));
    assign toggle_cnt = r_tog;
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_prev <= '0;
            r_tog  <= '0;
        end else if (w_acc) begin
            r_prev <= r_word;
            r_tog  <= w_tsum[32] ? '1 : w_tsum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_adder_flit_injector.sv
// tb_adder_flit_injector: directed checks of packet framing, walk sequence, stalls and reset
module tb_adder_flit_injector;
    localparam int N = 25;
    localparam int W = 2 * N;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [15:0] num_pkts = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [N-1:0] operand_a, operand_b;
    logic        out_last, busy, done;
    int          total = 0;
    int          bad = 0;
`ifdef INJ_TOGGLE_COUNT_EN
    logic [31:0] toggle_cnt;
`endif
    adder_flit_injector #(.N(N), .PAYLOAD(20), .GAP(7), .STEP(7), .PKT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_pkts  (num_pkts),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef INJ_TOGGLE_COUNT_EN
        ,
        .toggle_cnt(toggle_cnt)
`endif
    );
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mword(input int p, input bit ph);
        logic [63:0] low;
        low = (64'd1 << (W - p)) - 64'd1;
        return ph ? low[W-1:0] : ~low[W-1:0];
    endfunction

    task automatic run(input int np, input bit rnd, input int poke, input bit start_on_done, input string nm);
        int mp = 0, fidx = 0, pkt = 0, nflits = 0, gaps = 0, last_c = -1;
        bit mph = 0, done_seen = 0, stalled = 0;
        logic [W-1:0] ew, prevw = '0, held = '0;
        logic [63:0] mtog = 0;
        num_pkts = 16'(np);
        start = 1;
        tick();
        start = 0;
        chk({nm, "_busy_after_start"}, busy, 1);
        chk({nm, "_valid_after_start"}, out_valid, np != 0);
`ifdef INJ_TOGGLE_COUNT_EN
        chk({nm, "_tog_cleared"}, toggle_cnt, 0);
`endif
        mp = 7;
        for (int c = 0; c < 3000 && !done_seen; c++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = c == poke;
            if (c == poke) num_pkts = 3;
            if (done) begin
                done_seen = 1;
                chk({nm, "_flit_count"}, nflits, np * 20);
                chk({nm, "_done_lag"}, c - last_c, 1);
                chk({nm, "_valid_in_done"}, out_valid, 0);
`ifdef INJ_TOGGLE_COUNT_EN
                chk({nm, "_tog_done"}, toggle_cnt, mtog);
`endif
                if (start_on_done) start = 1;
            end else if (out_valid) begin
                ew = mword(mp, mph);
                if (pkt > 0 && fidx == 0 && gaps >= 0) begin
                    chk({nm, "_gap_len"}, gaps, 7);
                    gaps = -1;
                end
                if (stalled) chk({nm, "_stall_hold"}, {operand_b, operand_a}, held);
                chk({nm, "_word"}, {operand_b, operand_a}, ew);
                chk({nm, "_last"}, out_last, fidx == 19);
                if (fidx == 0) chk({nm, "_flit0_b"}, operand_b, 25'h1FC0000);
                if (fidx == 0) chk({nm, "_flit0_a"}, operand_a, 0);
                if (fidx == 6) chk({nm, "_flit_p49"}, {operand_b, operand_a}, 50'h3FFFFFFFFFFFE);
                if (fidx == 7) chk({nm, "_flit_wrap"}, {operand_b, operand_a}, 50'h00FFFFFFFFFFF);
                stalled = !out_ready;
                held = {operand_b, operand_a};
                if (out_ready) begin
                    nflits++;
                    last_c = c;
                    mtog += 64'($countones(ew ^ prevw));
                    prevw = ew;
                    fidx++;
                    mp += 7;
                    if (mp > W) begin
                        mp -= W;
                        mph = ~mph;
                    end
                    if (fidx == 20) begin
                        fidx = 0;
                        pkt++;
                        mp = 7;
                        mph = 0;
                        gaps = 0;
                    end
                end
            end else if (gaps >= 0) gaps++;
            tick();
        end
        start = 0;
        chk({nm, "_done_timeout"}, done_seen, 1);
        chk({nm, "_done_pulse_len"}, done, 0);
        chk({nm, "_busy_end"}, busy, 0);
        chk({nm, "_valid_end"}, out_valid, 0);
`ifdef INJ_TOGGLE_COUNT_EN
        chk({nm, "_tog_hold"}, toggle_cnt, mtog);
`endif
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ops", {operand_b, operand_a}, 0);
        rst = 0;
        tick();
        run(1, 0, -1, 0, "one_pkt");
`ifdef INJ_TOGGLE_COUNT_EN
        chk("tog_140", toggle_cnt, 140);
`endif
        run(3, 0, -1, 0, "three_pkt");
        run(1, 1, -1, 0, "rand_ready");
        run(0, 0, -1, 1, "zero_pkt");
        run(1, 0, 5, 0, "start_busy");
        num_pkts = 1;
        out_ready = 1;
        start = 1;
        tick();
        start = 0;
        repeat (10) tick();
        chk("mid_rst_valid_pre", out_valid, 1);
        rst = 1;
        tick();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_ops", {operand_b, operand_a}, 0);
        rst = 0;
        tick();
        run(1, 0, -1, 0, "after_rst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
